// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline datapath sequencers.
//   Provides the sequencer state type and the fixed block geometry used by the
//   16-byte to 32-bit lane mux sequencer.
//
//   Contents:
//     seq_state_t    : sequencer state (S_IDLE = no block held, S_SEND = streaming)
//     NUM_BYTES      : bytes per input block
//     WORDS_PER_BLK  : 32-bit words per full block
//     SEL_W          : width of the lane-mux select
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } seq_state_t;

    localparam int NUM_BYTES     = 16;
    localparam int WORDS_PER_BLK = 4;
    localparam int SEL_W         = $clog2(WORDS_PER_BLK);

endpackage

// File: rtl/mux_pipeline_seq.sv
// -----------------------------------------------------------------------------
// mux_pipeline_seq
//   Sequencer for the external 16-byte to 32-bit lane mux. Accepts one block
//   over a valid/ready handshake, holds it stable on mux_bytes and walks
//   mux_ctrl through 0..last_idx, one word per downstream handshake. The mux
//   result (mux_data) is forwarded unregistered as out_data.
//
//   Ports:
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     flush            synchronous abort: drop held block, return to idle
//     cfg_words        words per block minus 1, sampled at block accept
//     in_valid/ready   upstream block handshake
//     in_data          block, byte i = in_data[8*i +: 8]
//     mux_bytes        held block to the mux
//     mux_ctrl         mux select, k selects bytes 4k..4k+3
//     mux_data         mux output
//     out_valid/ready  downstream word handshake
//     out_data         = mux_data
//     out_last         current word is the last of the block
//     blk_done         one-cycle pulse after a block's last word transfers
//     blk_count        completed blocks, wrapping
//     busy             a block is held
// -----------------------------------------------------------------------------
module mux_pipeline_seq
    import pipe_pkg::*;
#(
    parameter int NUM_BYTES = 16,
    parameter int BYTE_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [SEL_W-1:0]            cfg_words,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_BYTES*BYTE_W-1:0] in_data,
    output logic [NUM_BYTES*BYTE_W-1:0] mux_bytes,
    output logic [SEL_W-1:0]            mux_ctrl,
    input  logic [4*BYTE_W-1:0]         mux_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4*BYTE_W-1:0]         out_data,
    output logic                        out_last,
    output logic                        blk_done,
    output logic [CNT_W-1:0]            blk_count,
    output logic                        busy
);

    seq_state_t                  state;
    seq_state_t                  state_next;
    logic [SEL_W-1:0]            word_idx;
    logic [SEL_W-1:0]            word_idx_next;
    logic [SEL_W-1:0]            last_idx;
    logic [SEL_W-1:0]            last_idx_next;
    logic [NUM_BYTES*BYTE_W-1:0] hold_reg;
    logic                        load_blk;
    logic                        blk_done_next;
    logic                        count_inc;
    logic                        out_hs;
    logic                        in_hs;
    logic                        last_hs;

    // Handshake decode and output view of the state. The mux select is
    // forced to zero when idle so the mux sees a quiet select between blocks.
    // in_ready opens on the last-word handshake so a new block can be loaded
    // in the same cycle the old one finishes, giving zero-bubble streaming.
    always_comb begin
        out_valid = (state == S_SEND);
        out_last  = out_valid && (word_idx == last_idx);
        mux_ctrl  = out_valid ? word_idx : '0;
        out_hs    = out_valid && out_ready;
        last_hs   = out_hs && out_last;
        in_ready  = !flush && (!out_valid || last_hs);
        in_hs     = in_valid && in_ready;
        busy      = out_valid;
        mux_bytes = hold_reg;
        out_data  = mux_data;
    end

    // Next-state logic. flush overrides everything: the held block is
    // abandoned without a completion pulse or count, even if its word
    // transferred this cycle. in_hs can never coincide with flush because
    // in_ready is forced low then.
    always_comb begin
        state_next    = state;
        word_idx_next = word_idx;
        last_idx_next = last_idx;
        load_blk      = 1'b0;
        blk_done_next = 1'b0;
        count_inc     = 1'b0;

        if (flush) begin
            state_next    = S_IDLE;
            word_idx_next = '0;
        end else begin
            blk_done_next = last_hs;
            count_inc     = last_hs;
            if (in_hs) begin
                load_blk      = 1'b1;
                state_next    = S_SEND;
                word_idx_next = '0;
                last_idx_next = cfg_words;
            end else if (last_hs) begin
                state_next    = S_IDLE;
                word_idx_next = '0;
            end else if (out_hs) begin
                word_idx_next = word_idx + 1'b1;
            end
        end
    end

    // State, word position and block length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            word_idx <= '0;
            last_idx <= '0;
        end else begin
            state    <= state_next;
            word_idx <= word_idx_next;
            last_idx <= last_idx_next;
        end
    end

    // Block hold register. Only written at accept, so the mux input stays
    // stable for the whole block including stalls; it keeps the old block
    // while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
        end else if (load_blk) begin
            hold_reg <= in_data;
        end
    end

    // Completion pulse and wrapping completed-block counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_done  <= 1'b0;
            blk_count <= '0;
        end else begin
            blk_done <= blk_done_next;
            if (count_inc) begin
                blk_count <= blk_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_pipeline_seq.sv
// -----------------------------------------------------------------------------
// tb_mux_pipeline_seq
//   Bench for mux_pipeline_seq together with a behavioural lane mux. A
//   transaction-level model (queue of pending words for the held block, a
//   completion flag and a block counter) supplies the expected outputs.
// -----------------------------------------------------------------------------
module tb_mux_pipeline_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   cfg_words = 2'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] mux_bytes;
    logic [1:0]   mux_ctrl;
    logic [31:0]  mux_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic         blk_done;
    logic [15:0]  blk_count;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_pipeline_seq #(.NUM_BYTES(16), .BYTE_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .cfg_words (cfg_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mux_bytes (mux_bytes),
        .mux_ctrl  (mux_ctrl),
        .mux_data  (mux_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .blk_done  (blk_done),
        .blk_count (blk_count),
        .busy      (busy)
    );

    // Lane mux beside the sequencer: lowest-numbered byte of the group is MSB.
    always_comb begin
        mux_data = {mux_bytes[{mux_ctrl, 5'd0} +: 8],
                    mux_bytes[{mux_ctrl, 5'd0} + 7'd8 +: 8],
                    mux_bytes[{mux_ctrl, 5'd0} + 7'd16 +: 8],
                    mux_bytes[{mux_ctrl, 5'd0} + 7'd24 +: 8]};
    end

    // Word k of a block as the downstream side should see it.
    function automatic logic [31:0] word_of(input logic [127:0] d, input int k);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) begin
            w[31-8*b -: 8] = d[8*(4*k+b) +: 8];
        end
        return w;
    endfunction

    // Reference model: pending words of the held block, position within it.
    logic [31:0]  m_q[$];
    int           m_pos;
    bit           m_done;
    int unsigned  m_count;
    logic [127:0] m_blk;

    function automatic bit exp_in_ready();
        return !flush && (m_q.size() == 0 || (out_ready && m_q.size() == 1));
    endfunction

    // Model update on each clock edge from the inputs presented in that cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pos   = 0;
            m_done  = 0;
            m_count = 0;
            m_blk   = '0;
        end else begin : model_step
            bit ev, hs_out, lastw, hs_in;
            ev     = (m_q.size() != 0);
            hs_out = ev && out_ready;
            lastw  = ev && (m_q.size() == 1);
            hs_in  = in_valid && exp_in_ready();
            if (flush) begin
                m_q.delete();
                m_pos  = 0;
                m_done = 0;
            end else begin
                m_done = hs_out && lastw;
                if (m_done) m_count++;
                if (hs_out) begin
                    void'(m_q.pop_front());
                    m_pos++;
                end
                if (hs_in) begin
                    m_q.delete();
                    m_blk = in_data;
                    m_pos = 0;
                    for (int k = 0; k <= int'(cfg_words); k++) m_q.push_back(word_of(in_data, k));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (mux_ctrl !== 2'd0) begin errors++; $display("[TB] FAIL reset_mux_ctrl got=%0d want=0", mux_ctrl); end
        checks++; if (mux_bytes !== 128'd0) begin errors++; $display("[TB] FAIL reset_mux_bytes got=%h want=0", mux_bytes); end
        checks++; if (blk_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_blk_count got=%0d want=0", blk_count); end
        checks++; if (blk_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_blk_done got=%0b want=0", blk_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready); end
        next_cycle();
    endtask

    task automatic test_full_block();
        logic [127:0] d;
        logic [31:0]  exp_w [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
        in_valid = 1'b1; in_data = d; cfg_words = 2'd3; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_accept_ready got=%0b want=1", in_ready); end
        next_cycle();
        in_valid = 1'b0; cfg_words = 2'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_valid w%0d got=%0b want=1", k, out_valid); end
            checks++; if (out_data !== exp_w[k]) begin errors++; $display("[TB] FAIL full_data w%0d got=%h want=%h", k, out_data, exp_w[k]); end
            checks++; if (mux_ctrl !== 2'(k)) begin errors++; $display("[TB] FAIL full_ctrl w%0d got=%0d want=%0d", k, mux_ctrl, k); end
            checks++; if (out_last !== (k == 3)) begin errors++; $display("[TB] FAIL full_last w%0d got=%0b want=%0b", k, out_last, k == 3); end
            checks++; if (blk_done !== 1'b0) begin errors++; $display("[TB] FAIL full_done_early w%0d got=%0b want=0", k, blk_done); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (blk_done !== 1'b1) begin errors++; $display("[TB] FAIL full_blk_done got=%0b want=1", blk_done); end
        checks++; if (blk_count !== 16'd1) begin errors++; $display("[TB] FAIL full_blk_count got=%0d want=1", blk_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_idle_valid got=%0b want=0", out_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (blk_done !== 1'b0) begin errors++; $display("[TB] FAIL full_done_pulse got=%0b want=0", blk_done); end
        next_cycle();
    endtask

    task automatic test_short_block();
        logic [127:0] d;
        d = rand_blk();
        in_valid = 1'b1; in_data = d; cfg_words = 2'd1; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0; cfg_words = 2'd3;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL short_valid w%0d got=%0b want=1", k, out_valid); end
            checks++; if (out_data !== word_of(d, k)) begin errors++; $display("[TB] FAIL short_data w%0d got=%h want=%h", k, out_data, word_of(d, k)); end
            checks++; if (mux_ctrl !== 2'(k)) begin errors++; $display("[TB] FAIL short_ctrl w%0d got=%0d want=%0d", k, mux_ctrl, k); end
            checks++; if (out_last !== (k == 1)) begin errors++; $display("[TB] FAIL short_last w%0d got=%0b want=%0b", k, out_last, k == 1); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL short_end_valid got=%0b want=0", out_valid); end
        checks++; if (blk_done !== 1'b1) begin errors++; $display("[TB] FAIL short_blk_done got=%0b want=1", blk_done); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        int           words;
        d = rand_blk();
        words = 0;
        in_valid = 1'b1; in_data = d; cfg_words = 2'd3; out_ready = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            out_ready = c[0];
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid c%0d got=%0b want=1", c, out_valid); end
            checks++; if (out_data !== word_of(d, words)) begin errors++; $display("[TB] FAIL bp_data c%0d got=%h want=%h", c, out_data, word_of(d, words)); end
            checks++; if (mux_ctrl !== 2'(words)) begin errors++; $display("[TB] FAIL bp_ctrl c%0d got=%0d want=%0d", c, mux_ctrl, words); end
            checks++; if (mux_bytes !== d) begin errors++; $display("[TB] FAIL bp_bytes c%0d got=%h want=%h", c, mux_bytes, d); end
            if (out_ready) words++;
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_end_valid got=%0b want=0", out_valid); end
        checks++; if (blk_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_blk_done got=%0b want=1", blk_done); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [127:0] b [3];
        int           accepted;
        logic [15:0]  cnt0;
        for (int i = 0; i < 3; i++) b[i] = rand_blk();
        accepted = 0;
        cnt0 = blk_count;
        in_valid = 1'b1; in_data = b[0]; cfg_words = 2'd3; out_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            checks++; if (in_ready !== (c % 4 == 0)) begin errors++; $display("[TB] FAIL b2b_in_ready c%0d got=%0b want=%0b", c, in_ready, c % 4 == 0); end
            checks++; if (out_valid !== (c != 0)) begin errors++; $display("[TB] FAIL b2b_valid c%0d got=%0b want=%0b", c, out_valid, c != 0); end
            if (c != 0) begin
                checks++;
                if (out_data !== word_of(b[(c-1)/4], (c-1)%4)) begin
                    errors++; $display("[TB] FAIL b2b_data c%0d got=%h want=%h", c, out_data, word_of(b[(c-1)/4], (c-1)%4));
                end
            end
            if (in_valid && (c % 4 == 0)) accepted++;
            next_cycle();
            if (accepted < 3) in_data = b[accepted];
            else in_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (blk_count !== 16'(cnt0 + 16'd3)) begin errors++; $display("[TB] FAIL b2b_blk_count got=%0d want=%0d", blk_count, cnt0 + 16'd3); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end_valid got=%0b want=0", out_valid); end
        next_cycle();
    endtask

    task automatic test_flush_and_reset();
        logic [15:0] cnt0;
        cnt0 = 16'(m_count);
        in_valid = 1'b1; in_data = rand_blk(); cfg_words = 2'd3; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready got=%0b want=0", in_ready); end
        checks++; if (mux_ctrl !== 2'd1) begin errors++; $display("[TB] FAIL flush_ctrl got=%0d want=1", mux_ctrl); end
        next_cycle();
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid c%0d got=%0b want=0", c, out_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy c%0d got=%0b want=0", c, busy); end
            checks++; if (blk_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_blk_done c%0d got=%0b want=0", c, blk_done); end
            checks++; if (blk_count !== cnt0) begin errors++; $display("[TB] FAIL flush_blk_count c%0d got=%0d want=%0d", c, blk_count, cnt0); end
            next_cycle();
        end
        in_valid = 1'b1; in_data = rand_blk(); cfg_words = 2'd3;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got=%0b want=0", out_valid); end
        checks++; if (mux_ctrl !== 2'd0) begin errors++; $display("[TB] FAIL rst_mid_ctrl got=%0d want=0", mux_ctrl); end
        checks++; if (mux_bytes !== 128'd0) begin errors++; $display("[TB] FAIL rst_mid_bytes got=%h want=0", mux_bytes); end
        checks++; if (blk_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_count got=%0d want=0", blk_count); end
        checks++; if (blk_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done got=%0b want=0", blk_done); end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_words = 2'($urandom_range(0, 3));
            in_data   = rand_blk();
            flush     = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            checks++; if (in_ready !== exp_in_ready()) begin errors++; $display("[TB] FAIL rnd_in_ready c%0d got=%0b want=%0b", c, in_ready, exp_in_ready()); end
            checks++; if (out_valid !== (m_q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid c%0d got=%0b want=%0b", c, out_valid, m_q.size() != 0); end
            checks++; if (busy !== (m_q.size() != 0)) begin errors++; $display("[TB] FAIL rnd_busy c%0d got=%0b want=%0b", c, busy, m_q.size() != 0); end
            checks++; if (blk_done !== m_done) begin errors++; $display("[TB] FAIL rnd_done c%0d got=%0b want=%0b", c, blk_done, m_done); end
            checks++; if (blk_count !== 16'(m_count)) begin errors++; $display("[TB] FAIL rnd_count c%0d got=%0d want=%0d", c, blk_count, 16'(m_count)); end
            if (m_q.size() != 0) begin
                checks++; if (out_data !== m_q[0]) begin errors++; $display("[TB] FAIL rnd_data c%0d got=%h want=%h", c, out_data, m_q[0]); end
                checks++; if (out_last !== (m_q.size() == 1)) begin errors++; $display("[TB] FAIL rnd_last c%0d got=%0b want=%0b", c, out_last, m_q.size() == 1); end
                checks++; if (mux_ctrl !== 2'(m_pos)) begin errors++; $display("[TB] FAIL rnd_ctrl c%0d got=%0d want=%0d", c, mux_ctrl, m_pos); end
                checks++; if (mux_bytes !== m_blk) begin errors++; $display("[TB] FAIL rnd_bytes c%0d got=%h want=%h", c, mux_bytes, m_blk); end
            end else begin
                checks++; if (mux_ctrl !== 2'd0) begin errors++; $display("[TB] FAIL rnd_idle_ctrl c%0d got=%0d want=0", c, mux_ctrl); end
            end
            next_cycle();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_short_block();
        test_backpressure();
        test_back_to_back();
        test_flush_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
